// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, ECALL encoding and FSM state type shared by the fetch stage.
package fetch_unit_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [31:0] ECALL   = 32'h00000073;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return rd != 5'd0 && (op inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, instruction-memory and downstream handshake signals of the fetch stage.
interface fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic              reg_write;
    logic              halted;

    modport master (
        input  start, redirect_valid, redirect_addr, mem_rdata, inst_ready,
        output mem_addr, inst_valid, inst, inst_addr, reg_write, halted
    );
    modport slave (
        output start, redirect_valid, redirect_addr, mem_rdata, inst_ready,
        input  mem_addr, inst_valid, inst, inst_addr, reg_write, halted
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {inst, addr} with push/pop/flush; head entry always visible.
module fetch_queue #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] addr_o
);
    logic [DATA_W+ADDR_W-1:0] mem_q [2];
    logic [1:0] count_q, count_d;
    logic       head_q, head_d, wr;

    // With one entry the free slot is the other one; otherwise it is the head slot
    // (empty, or full and being popped this cycle).
    assign wr      = head_q ^ (count_q == 2'd1);
    assign count_d = flush_i ? 2'd0 : count_q + {1'b0, push_i} - {1'b0, pop_i};
    assign head_d  = head_q ^ pop_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
            head_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (push_i && !flush_i) mem_q[wr] <= {inst_i, addr_i};
        end
    end

    assign {inst_o, addr_o} = mem_q[head_q];
    assign count_o          = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: self-sequencing instruction fetch with PC, 2-entry queue and reg_write decode.
// Optional FETCH_HALT_EN: a fetched ECALL halts fetching until the next redirect.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        count;
    logic              push, pop;

    assign pop  = bus.inst_valid && bus.inst_ready;
    assign push = state_q == RUN && !bus.redirect_valid && (count != 2'd2 || pop);

    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) state_d = RUN;
        else if (state_q == IDLE && bus.start) state_d = RUN;
`ifdef FETCH_HALT_EN
        else if (push && bus.mem_rdata == ECALL) state_d = HALT;
`endif
    end

    assign pc_d = bus.redirect_valid ? bus.redirect_addr : push ? pc_q + 1'b1 : pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .inst_i  (bus.mem_rdata),
        .addr_i  (pc_q),
        .count_o (count),
        .inst_o  (bus.inst),
        .addr_o  (bus.inst_addr)
    );

    assign bus.mem_addr   = pc_q;
    assign bus.inst_valid = count != 2'd0;
    assign bus.reg_write  = bus.inst_valid && writes_rd(bus.inst[6:0], bus.inst[11:7]);
`ifdef FETCH_HALT_EN
    assign bus.halted = state_q == HALT;
`else
    assign bus.halted = 1'b0;
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the register-file/ALU datapath. It owns the program counter, drives the word address into the instruction memory, and buffers fetched words in a 2-entry queue. It presents them downstream with a valid/ready handshake together with the register-write enable for the presented instruction. It replaces the externally driven instruction address and regWrite strobe with a self-sequencing front end.

## Interface
- ADDR_W, 5, word-address width; PC range 0..2^ADDR_W-1
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; IDLE -> RUN
- redirect_valid  in  1  load PC from redirect_addr, flush queue
- redirect_addr  in  ADDR_W  redirect target word address
- mem_addr  out  ADDR_W  address to instruction memory, equals PC
- mem_rdata  in  DATA_W  combinational instruction memory read data
- inst_valid  out  1  queue head holds an instruction
- inst_ready  in  1  downstream accepts head this cycle
- inst  out  DATA_W  queue-head instruction
- inst_addr  out  ADDR_W  word address of queue-head instruction
- reg_write  out  1  head opcode writes rd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111; 0 if rd==0 or !inst_valid
- halted  out  1  state == HALT

## Operation
- States: IDLE (reset), RUN, HALT.
- IDLE -> RUN on start. RUN -> HALT when an ECALL is pushed (see Configuration). Any state -> RUN on redirect_valid. start is ignored outside IDLE.
- push = (state==RUN) && !redirect_valid && (count<2 || pop).
- pop = inst_valid && inst_ready.
- On push: {mem_rdata, PC} enters the tail and PC <= PC+1 mod 2^ADDR_W. 31 wraps to 0 with no other effect.
- On redirect_valid: PC <= redirect_addr, count <= 0, state <= RUN. Redirect beats push. A simultaneous pop is still a completed transfer.
- Queue: 2 entries, count 0..2. Push and pop in the same cycle are legal at any count, including 2. The count is unchanged and the order is preserved.
- Queue empty: inst_valid=0, inst/inst_addr hold last value, don't-care.
- Queue full, no pop: push=0, PC holds.
- reg_write is combinational from the head entry only.

## Timing
- Reset values: PC=RESET_PC, count=0, state=IDLE, inst_valid=0, reg_write=0, halted=0, inst=0, inst_addr=0. mem_addr=RESET_PC.
- Fetch latency: the word at PC is captured at the push edge. inst_valid rises in the next cycle. First instruction after start appears 2 cycles after the start pulse edge.
- Redirect latency: first instruction from redirect_addr is valid 2 edges after the redirect edge.
- Sustained throughput of 1 instruction/cycle with inst_ready held high.
- inst, inst_addr and inst_valid are stable while inst_valid=1 and inst_ready=0.
- Async rst mid-operation clears the queue and state immediately. Buffered instructions are lost.

## Configuration
- FETCH_HALT_EN defined: a pushed word equal to 32'h00000073 (ECALL) moves RUN -> HALT on the same edge. The ECALL is still delivered downstream. PC = ECALL address + 1, frozen. Only redirect_valid leaves HALT.
- FETCH_HALT_EN undefined: ECALL is an ordinary instruction. The HALT state is unreachable and halted is tied 0.

## Structure
- Shared package: opcode constants (OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR), ECALL encoding, state enum {IDLE, RUN, HALT}.
- One sub-module: fetch_queue (2-entry FIFO of {inst, addr} with push/pop/flush/count). PC, FSM and reg_write decode stay in the top level.

## Test plan
- Reset, start, inst_ready=1, memory words 0..3 = ADD/ADDI/SW/LW: inst_addr 0,1,2,3 on consecutive cycles from cycle 2. reg_write = 1,1,0,1.
- inst_ready=0 for 5 cycles after start: count saturates at 2, PC=2. Raise ready: addresses 0,1,2 with no gap or duplicate.
- Redirect to 20 while count=2 with a simultaneous pop of addr 4: addr 4 counted as delivered. Addr 5 flushed. Next valid is addr 20, two edges later.
- PC runs 30,31 then wraps: delivered addresses 30,31,0 in order.
- FETCH_HALT_EN, ECALL at addr 3: addr 3 delivered, halted=1, PC=4, no further valid. Redirect to 0 resumes from 0.
- rst asserted mid-stream with count=2: inst_valid drops immediately. State returns to IDLE with PC=RESET_PC, and no fetch occurs until start.
